// File: rtl/spi_pwm_phy.sv
// SPI mode-0 byte slave and single-channel PWM generator sharing one clock.
// The PWM period is derived from a frequency in Hz by a sequential restoring divider.
module spi_pwm_phy #(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic        rx_byte_available,
  output logic [7:0]  rx_byte,
  output logic        tx_read_to_write,
  input  logic [7:0]  tx_byte,
  input  logic [15:0] freq,
  input  logic [15:0] duty_cycle_usec,
  output logic        pwm_pin
);

  localparam int unsigned TICK_DIV  = CLK_HZ / 1000000;
  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [19:0]   DIVIDEND  = 20'd1000000;

  // ---------------------------------------------------------------------------
  // SPI input synchronisers; ss resets high so reset never looks like a select.
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q [SYNC_STAGES];
  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_q, ss_q;
  logic       sclk_rise, sclk_fall, ss_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b100;
      sclk_q <= 1'b0;
      ss_q   <= 1'b1;
    end else begin
      sync_q[0] <= {ss, mosi, sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_q <= sclk_s;
      ss_q   <= ss_s;
    end
  end

  assign {ss_s, mosi_s, sclk_s} = sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign ss_fall   = ~ss_s & ss_q;

  // ---------------------------------------------------------------------------
  // SPI byte engine.
  // Handshake: rx_byte_available is a level that rises one clk after rx_byte is
  // updated; the controller reacts to its rising edge. tx_read_to_write rises on
  // the same clk and marks the window in which tx_byte may be written; it drops
  // when the sclk falling edge after the 8th bit reloads the tx shift register.
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       avail_pend;
  logic       reload_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt           <= 3'd0;
      rx_shift          <= 7'd0;
      tx_shift          <= 8'd0;
      avail_pend        <= 1'b0;
      reload_pend       <= 1'b0;
      rx_byte           <= 8'd0;
      rx_byte_available <= 1'b0;
      tx_read_to_write  <= 1'b1;
      miso              <= 1'b0;
    end else if (ss_s) begin
      bit_cnt           <= 3'd0;
      rx_shift          <= 7'd0;
      avail_pend        <= 1'b0;
      reload_pend       <= 1'b0;
      rx_byte_available <= 1'b0;
      tx_read_to_write  <= 1'b1;
      miso              <= 1'b0;
    end else begin
      if (avail_pend) begin
        rx_byte_available <= 1'b1;
        tx_read_to_write  <= 1'b1;
        avail_pend        <= 1'b0;
      end

      if (ss_fall) begin
        tx_shift         <= tx_byte;
        miso             <= tx_byte[7];
        tx_read_to_write <= 1'b0;
      end else if (sclk_fall) begin
        if (reload_pend) begin
          tx_shift         <= tx_byte;
          miso             <= tx_byte[7];
          tx_read_to_write <= 1'b0;
          reload_pend      <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          miso     <= tx_shift[6];
        end
      end

      if (sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte     <= {rx_shift, mosi_s};
          avail_pend  <= 1'b1;
          reload_pend <= 1'b1;
        end else if (bit_cnt == 3'd0) begin
          rx_byte_available <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Period divider: period_us = floor(1000000 / freq), one quotient bit per clk.
  // div_src is the freq the quotient belongs to; freq=0 short-circuits to 0.
  // ---------------------------------------------------------------------------
  typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

  div_state_t  div_state, div_state_nxt;
  logic        div_start, div_zero;
  logic [15:0] div_src;
  logic [15:0] div_rem;
  logic [19:0] div_quo;
  logic [4:0]  div_cnt;
  logic [16:0] div_trial, div_diff;
  logic        div_ge;
  logic        div_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_state <= DIV_IDLE;
    else     div_state <= div_state_nxt;
  end

  always_comb begin
    div_state_nxt = div_state;
    div_start     = 1'b0;
    div_zero      = 1'b0;
    case (div_state)
      DIV_IDLE: begin
        if (freq != div_src) begin
          if (freq == 16'd0) begin
            div_zero = 1'b1;
          end else begin
            div_start     = 1'b1;
            div_state_nxt = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        if (div_cnt == 5'd0) div_state_nxt = DIV_IDLE;
      end
      default: div_state_nxt = DIV_IDLE;
    endcase
  end

  assign div_trial = {div_rem, DIVIDEND[div_cnt]};
  assign div_ge    = div_trial >= {1'b0, div_src};
  assign div_diff  = div_trial - {1'b0, div_src};
  assign div_done  = (div_state == DIV_IDLE) && (div_src == freq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_src <= 16'd0;
      div_rem <= 16'd0;
      div_quo <= 20'd0;
      div_cnt <= 5'd0;
    end else if (div_zero) begin
      div_src <= 16'd0;
      div_quo <= 20'd0;
    end else if (div_start) begin
      div_src <= freq;
      div_rem <= 16'd0;
      div_quo <= 20'd0;
      div_cnt <= 5'd19;
    end else if (div_state == DIV_RUN) begin
      div_rem <= div_ge ? div_diff[15:0] : div_trial[15:0];
      div_quo <= {div_quo[18:0], div_ge};
      div_cnt <= div_cnt - 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM timebase and output. A zero period means idle: counters held, pin low,
  // and settings are re-latched every clk until a non-zero period arrives.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic [19:0]   us_cnt;
  logic [19:0]   period_lat;
  logic [15:0]   duty_lat;
  logic          running, tick, boundary, latch_en;

  assign running  = (period_lat != 20'd0);
  assign tick     = running && (presc == PRESC_MAX);
  assign boundary = tick && (us_cnt == period_lat - 20'd1);
  assign latch_en = !running || boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      us_cnt     <= 20'd0;
      period_lat <= 20'd0;
      duty_lat   <= 16'd0;
      pwm_pin    <= 1'b0;
    end else begin
      if (latch_en) begin
        duty_lat <= duty_cycle_usec;
        if (div_done) period_lat <= div_quo;
      end

      if (!running) begin
        presc  <= '0;
        us_cnt <= 20'd0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) us_cnt <= boundary ? 20'd0 : us_cnt + 20'd1;
      end

      pwm_pin <= running && (us_cnt < {4'd0, duty_lat});
    end
  end

endmodule

// File: tb/tb_spi_pwm_phy.sv
// Directed bench for spi_pwm_phy: SPI byte transfers with a receive scoreboard,
// and table-driven PWM measurements plus frequency-change and reset sequences.
module tb_spi_pwm_phy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        miso;
  logic        rx_byte_available;
  logic [7:0]  rx_byte;
  logic        tx_read_to_write;
  logic [7:0]  tx_byte = 8'h00;
  logic [15:0] freq = 16'd0;
  logic [15:0] duty_cycle_usec = 16'd0;
  logic        pwm_pin;

  int checks = 0;
  int failures = 0;
  int avail_edges = 0;
  logic avail_prev = 1'b0;
  logic [7:0] exp_q[$];

  spi_pwm_phy #(.CLK_HZ(12000000), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .rx_byte_available(rx_byte_available), .rx_byte(rx_byte),
    .tx_read_to_write(tx_read_to_write), .tx_byte(tx_byte),
    .freq(freq), .duty_cycle_usec(duty_cycle_usec), .pwm_pin(pwm_pin)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every rx_byte_available rising edge must match the next expected byte
  always @(negedge clk) begin
    if (rx_byte_available && !avail_prev) begin
      avail_edges++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected_edge: got 0x%0h expected no byte", rx_byte);
      end else begin
        check("rx_byte_on_edge", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
      end
    end
    avail_prev = rx_byte_available;
  end

  // SPI host driver: sclk = CLK/16, mode 0, MSB first
  task automatic spi_xfer(input logic [7:0] data, input int nbits, input logic [7:0] next_tx,
                          output logic [7:0] host_rx);
    host_rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[7-i];
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      host_rx = {host_rx[6:0], miso};
      if (i == 7) begin
        repeat (6) @(negedge clk);
        check("tx_rtw_after_byte", {31'd0, tx_read_to_write}, 32'd1);
        tx_byte = next_tx;
        repeat (2) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic wait_rise(input int budget, output logic ok);
    logic prev;
    prev = pwm_pin;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pwm_pin && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = pwm_pin;
    end
  endtask

  // Called right after a rising edge was seen; measures up to the next rising edge.
  task automatic run_period(input int budget, input int change_at, input logic [15:0] new_freq,
                            output int len, output int high);
    logic prev;
    prev = 1'b1;
    len = 0;
    high = 1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == change_at) freq = new_freq;
      len = i;
      if (pwm_pin && !prev) break;
      if (pwm_pin) high++;
      prev = pwm_pin;
    end
  endtask

  typedef struct {
    logic [15:0] freq;
    logic [15:0] duty;
    int          window;
    int          exp_high;
    int          exp_edges;
  } pwm_vec_t;

  pwm_vec_t vecs[8];

  initial begin
    logic [7:0] rd;
    logic       ok;
    int         len, high, hi, edges;
    logic       prev;

    // window is one period in clks (12 clks per us); exp_high = duty_us * 12
    vecs[0] = '{16'd1000,  16'd250,  12000, 3000,  1};
    vecs[1] = '{16'd2000,  16'd100,  6000,  1200,  1};
    vecs[2] = '{16'd7000,  16'd50,   1704,  600,   1};  // floor(1e6/7000)=142 us
    vecs[3] = '{16'd65535, 16'd10,   180,   120,   1};  // floor(1e6/65535)=15 us
    vecs[4] = '{16'd2000,  16'd0,    6000,  0,     0};
    vecs[5] = '{16'd1000,  16'd2000, 12000, 12000, 0};
    vecs[6] = '{16'd2000,  16'd500,  6000,  6000,  0};  // duty == period
    vecs[7] = '{16'd0,     16'd250,  2000,  0,     0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_rx_avail", {31'd0, rx_byte_available}, 32'd0);
    check("rst_tx_rtw", {31'd0, tx_read_to_write}, 32'd1);
    check("rst_pwm", {31'd0, pwm_pin}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // SPI receive/transmit: two back-to-back bytes
    tx_byte = 8'h96;
    ss = 1'b0;
    repeat (8) @(negedge clk);
    check("ss_fall_tx_rtw", {31'd0, tx_read_to_write}, 32'd0);
    check("ss_fall_miso", {31'd0, miso}, 32'd1);
    exp_q.push_back(8'hA5);
    spi_xfer(8'hA5, 8, 8'h5A, rd);
    check("host_rd0", {24'd0, rd}, 32'h96);
    exp_q.push_back(8'h3C);
    spi_xfer(8'h3C, 8, 8'h00, rd);
    check("host_rd1", {24'd0, rd}, 32'h5A);
    repeat (4) @(negedge clk);
    check("rx_byte_3c", {24'd0, rx_byte}, 32'h3C);
    check("rx_avail_held", {31'd0, rx_byte_available}, 32'd1);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    check("ss_high_avail", {31'd0, rx_byte_available}, 32'd0);
    check("ss_high_miso", {31'd0, miso}, 32'd0);
    check("ss_high_tx_rtw", {31'd0, tx_read_to_write}, 32'd1);
    check("ss_high_rx_keep", {24'd0, rx_byte}, 32'h3C);

    // SPI abort after 4 bits, then a fresh 0xFF frame
    ss = 1'b0;
    repeat (8) @(negedge clk);
    spi_xfer(8'hA5, 4, 8'h00, rd);
    repeat (8) @(negedge clk);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_edge", avail_edges, 32'd2);
    check("abort_rx_keep", {24'd0, rx_byte}, 32'h3C);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'hFF);
    spi_xfer(8'hFF, 8, 8'h00, rd);
    repeat (4) @(negedge clk);
    check("rx_byte_ff", {24'd0, rx_byte}, 32'hFF);
    ss = 1'b1;
    repeat (6) @(negedge clk);
    check("rx_edge_count", avail_edges, 32'd3);
    check("rx_queue_empty", exp_q.size(), 32'd0);

    // PWM frequency change mid-period, then async reset mid-period
    rst = 1'b1;
    freq = 16'd1000;
    duty_cycle_usec = 16'd250;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_rise(13000, ok);
    check("pwm_first_rise", {31'd0, ok}, 32'd1);
    run_period(13000, 1000, 16'd500, len, high);
    check("chg_period_old", len, 32'd12000);
    check("chg_high_old", high, 32'd3000);
    run_period(25000, 0, 16'd500, len, high);
    check("chg_period_new", len, 32'd24000);
    check("chg_high_new", high, 32'd3000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_pwm", {31'd0, pwm_pin}, 32'd0);
    repeat (2) @(negedge clk);

    // PWM table
    for (int v = 0; v < 8; v++) begin
      rst = 1'b1;
      freq = vecs[v].freq;
      duty_cycle_usec = vecs[v].duty;
      apply_reset();
      repeat (64) @(negedge clk);
      hi = 0;
      edges = 0;
      prev = pwm_pin;
      for (int c = 0; c < vecs[v].window; c++) begin
        @(negedge clk);
        if (pwm_pin) hi++;
        if (pwm_pin && !prev) edges++;
        prev = pwm_pin;
      end
      check($sformatf("pwm_high[%0d]", v), hi, vecs[v].exp_high);
      check($sformatf("pwm_edges[%0d]", v), edges, vecs[v].exp_edges);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
